// File: rtl/serial_lane_arbiter.sv
// rtl/serial_lane_arbiter.sv - round-robin arbiter serialising N requesters' words onto one bit lane
// Optional early abort on dropped request: define SERIAL_LANE_ABORT_EN.
module serial_lane_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   data_in,
    output logic [N-1:0]         grant,
    output logic [N-1:0]         done,
    output logic                 lane_bit,
    output logic                 lane_valid,
    output logic                 lane_last,
    output logic                 busy
);

    localparam int PW = $clog2(N);
    localparam int CW = $clog2(WIDTH);
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     win;
    logic [PW-1:0]     pick;
    logic [PW-1:0]     cand;
    logic [CW-1:0]     count;
    logic [WIDTH-1:0]  shreg;
    logic [WIDTH-1:0]  word;
    logic              found;
    int                idx;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(N-1)) ? '0 : p + 1'b1;
    endfunction

    // First requester at or above ptr, wrapping modulo N.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        idx   = 0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            idx  = (int'(ptr) + k) % N;
            cand = PW'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        word = data_in[int'(pick)*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ptr        <= '0;
            win        <= '0;
            count      <= '0;
            shreg      <= '0;
            grant      <= '0;
            done       <= '0;
            lane_bit   <= 1'b0;
            lane_valid <= 1'b0;
            lane_last  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        // Bit 0 goes straight to the lane; the rest waits in shreg.
                        win        <= pick;
                        shreg      <= word >> 1;
                        lane_bit   <= word[0];
                        count      <= '0;
                        grant      <= ONE << pick;
                        lane_valid <= 1'b1;
                        lane_last  <= 1'b0;
                        busy       <= 1'b1;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
`ifdef SERIAL_LANE_ABORT_EN
                    if (!req[win]) begin
                        state      <= IDLE;
                        grant      <= '0;
                        lane_valid <= 1'b0;
                        lane_last  <= 1'b0;
                        lane_bit   <= 1'b0;
                        busy       <= 1'b0;
                        ptr        <= next_ptr(win);
                    end else
`endif
                    if (count == CW'(WIDTH-1)) begin
                        state      <= DONE;
                        grant      <= '0;
                        lane_valid <= 1'b0;
                        lane_last  <= 1'b0;
                        lane_bit   <= 1'b0;
                        done       <= grant;
                    end else begin
                        count     <= count + 1'b1;
                        lane_bit  <= shreg[0];
                        shreg     <= shreg >> 1;
                        lane_last <= (count == CW'(WIDTH-2));
                    end
                end
                DONE: begin
                    ptr   <= next_ptr(win);
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
